zif_prog_sequencer: RTL and testbench

- Downstream consumer of the bottom-half command interface. Executes one timed ZIF-socket operation per command: read a byte, program a byte with a VPP pulse, or verify a byte.
- The host-side write section issues commands with a toggle request; this block acks with a toggle.
- Runs entirely on the 24 MHz osc clock and replaces hand-written UDELAY chains in per-chip bottom halves.

---
 rtl/zif_prog_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_zif_prog_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/zif_prog_sequencer.sv
// ZIF-socket operation sequencer: executes one timed read, program or verify
// cycle per toggle-handshake command and acknowledges with a matching toggle.
// Everything runs on the 24 MHz oscillator; the request toggle is brought in
// through a two-flop synchronizer.
`timescale 1ns/1ps
module zif_prog_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int T_SETUP = 24,
    parameter int T_PULSE = 2400,
    parameter int T_HOLD  = 24,
    parameter int T_READ  = 12
) (
    input  logic              __osc,
    input  logic              __rst_n,
    input  logic              req_toggle,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic              ack_toggle,
    output logic              busy,
    output logic [7:0]        rdata,
    output logic              verify_fail,
    output logic [ADDR_W-1:0] zif_addr,
    output logic [7:0]        zif_dout,
    input  logic [7:0]        zif_din,
    output logic              zif_dout_en,
    output logic              zif_ce_n,
    output logic              zif_oe_n,
    output logic              zif_pgm_n,
    output logic              vpp_en
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_PULSE   = 3'd2,
        S_HOLD    = 3'd3,
        S_RSTROBE = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_PROG   = 2'b01;
    localparam logic [1:0] OP_VERIFY = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    // Each timed state lasts exactly T cycles: the counter is loaded with T-1
    // on entry and the state is left in the cycle where it reads zero.
    localparam logic [15:0] LD_SETUP = 16'(T_SETUP - 1);
    localparam logic [15:0] LD_PULSE = 16'(T_PULSE - 1);
    localparam logic [15:0] LD_HOLD  = 16'(T_HOLD - 1);
    localparam logic [15:0] LD_READ  = 16'(T_READ - 1);

    logic              sync1_q;
    logic              req_s_q;
    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              vfail_q, vfail_d;
    logic [ADDR_W-1:0] zaddr_q, zaddr_d;
    logic [7:0]        zdout_q, zdout_d;
    logic              dout_en_q, dout_en_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              pgm_n_q, pgm_n_d;
    logic              vpp_q, vpp_d;

    logic              pending_s;
    logic              cnt_zero_s;

    // A request is pending as long as the synchronized toggle differs from the ack.
    assign pending_s  = (req_s_q != ack_q);
    assign cnt_zero_s = (cnt_q == 16'd0);

    // Two-flop synchronizer for the request toggle coming from the write domain.
    always_ff @(posedge __osc or negedge __rst_n) begin
        if (!__rst_n) begin
            sync1_q <= 1'b0;
            req_s_q <= 1'b0;
        end else begin
            sync1_q <= req_toggle;
            req_s_q <= sync1_q;
        end
    end

    // State and delay-counter register.
    always_ff @(posedge __osc or negedge __rst_n) begin
        if (!__rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter-load logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero_s ? cnt_q : (cnt_q - 16'd1);
        case (state_q)
            S_IDLE: begin
                if (pending_s) begin
                    if (op == OP_RSVD) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETUP;
                        cnt_d   = LD_SETUP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (!cnt_zero_s) begin
                    state_d = S_SETUP;
                end else if (op_q == OP_PROG) begin
                    state_d = S_PULSE;
                    cnt_d   = LD_PULSE;
                end else begin
                    state_d = S_RSTROBE;
                    cnt_d   = LD_READ;
                end
            end
            S_PULSE: begin
                if (cnt_zero_s) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                end else begin
                    state_d = S_PULSE;
                end
            end
            S_HOLD: begin
                if (cnt_zero_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_RSTROBE: begin
                if (cnt_zero_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RSTROBE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Output next values: every output changes on the edge that enters or leaves
    // a state, so strobe widths track the state durations exactly.
    always_comb begin
        op_d      = op_q;
        wdata_d   = wdata_q;
        ack_d     = ack_q;
        busy_d    = busy_q;
        rdata_d   = rdata_q;
        vfail_d   = vfail_q;
        zaddr_d   = zaddr_q;
        zdout_d   = zdout_q;
        dout_en_d = dout_en_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        pgm_n_d   = pgm_n_q;
        vpp_d     = vpp_q;
        case (state_q)
            S_IDLE: begin
                if (pending_s) begin
                    op_d    = op;
                    wdata_d = wdata;
                    busy_d  = 1'b1;
                    vfail_d = 1'b0;
                    if (op != OP_RSVD) begin
                        zaddr_d = addr;
                        ce_n_d  = 1'b0;
                        if (op == OP_PROG) begin
                            zdout_d   = wdata;
                            dout_en_d = 1'b1;
                            vpp_d     = 1'b1;
                        end else begin
                            dout_en_d = 1'b0;
                            vpp_d     = 1'b0;
                        end
                    end else begin
                        ce_n_d = 1'b1;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_SETUP: begin
                if (cnt_zero_s) begin
                    if (op_q == OP_PROG) begin
                        pgm_n_d = 1'b0;
                    end else begin
                        oe_n_d = 1'b0;
                    end
                end else begin
                    ce_n_d = 1'b0;
                end
            end
            S_PULSE: begin
                if (cnt_zero_s) begin
                    pgm_n_d = 1'b1;
                end else begin
                    pgm_n_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (cnt_zero_s) begin
                    vpp_d     = 1'b0;
                    dout_en_d = 1'b0;
                    ce_n_d    = 1'b1;
                end else begin
                    pgm_n_d = 1'b1;
                end
            end
            S_RSTROBE: begin
                if (cnt_zero_s) begin
                    rdata_d = zif_din;
                    if (op_q == OP_VERIFY) begin
                        vfail_d = (zif_din != wdata_q);
                    end else begin
                        vfail_d = vfail_q;
                    end
                    oe_n_d = 1'b1;
                    ce_n_d = 1'b1;
                end else begin
                    oe_n_d = 1'b0;
                end
            end
            S_DONE: begin
                ack_d  = req_s_q;
                busy_d = 1'b0;
            end
            default: begin
                busy_d    = 1'b0;
                dout_en_d = 1'b0;
                vpp_d     = 1'b0;
                ce_n_d    = 1'b1;
                oe_n_d    = 1'b1;
                pgm_n_d   = 1'b1;
            end
        endcase
    end

    // Output and command-latch registers.
    always_ff @(posedge __osc or negedge __rst_n) begin
        if (!__rst_n) begin
            op_q      <= 2'b00;
            wdata_q   <= 8'h00;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            rdata_q   <= 8'h00;
            vfail_q   <= 1'b0;
            zaddr_q   <= '0;
            zdout_q   <= 8'h00;
            dout_en_q <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            pgm_n_q   <= 1'b1;
            vpp_q     <= 1'b0;
        end else begin
            op_q      <= op_d;
            wdata_q   <= wdata_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            rdata_q   <= rdata_d;
            vfail_q   <= vfail_d;
            zaddr_q   <= zaddr_d;
            zdout_q   <= zdout_d;
            dout_en_q <= dout_en_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            pgm_n_q   <= pgm_n_d;
            vpp_q     <= vpp_d;
        end
    end

    assign ack_toggle  = ack_q;
    assign busy        = busy_q;
    assign rdata       = rdata_q;
    assign verify_fail = vfail_q;
    assign zif_addr    = zaddr_q;
    assign zif_dout    = zdout_q;
    assign zif_dout_en = dout_en_q;
    assign zif_ce_n    = ce_n_q;
    assign zif_oe_n    = oe_n_q;
    assign zif_pgm_n   = pgm_n_q;
    assign vpp_en      = vpp_q;

endmodule

// File: tb/tb_zif_prog_sequencer.sv
// Bench for zif_prog_sequencer: a default-timing instance exercised with a
// scoreboard of expected completion results, plus a unit-timing instance for
// the minimum-duration and back-to-back cases.
`timescale 1ns/1ps
module tb_zif_prog_sequencer;

    typedef struct {
        logic [7:0] rdata;
        logic       vf;
        logic       ack;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          total;
    int          bad;

    // Instance A: default timing
    logic        req_a, ack_a, busy_a, vf_a, den_a, ce_a, oe_a, pgm_a, vpp_a;
    logic [1:0]  op_a;
    logic [15:0] addr_a, zaddr_a;
    logic [7:0]  wdata_a, rdata_a, zdout_a, din_a;

    // Instance B: every timed state one cycle long
    logic        req_b, ack_b, busy_b, vf_b, den_b, ce_b, oe_b, pgm_b, vpp_b;
    logic [1:0]  op_b;
    logic [15:0] addr_b, zaddr_b;
    logic [7:0]  wdata_b, rdata_b, zdout_b, din_b;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic        ack_prev;
    logic [7:0]  model_rd;
    logic [7:0]  exp_dout;
    int          ce_lo, oe_lo, pgm_lo, vpp_hi, den_hi, busy_hi, dout_bad, ovl;
    int          pgm_b_lo, oe_b_lo;

    zif_prog_sequencer dut_a (
        .__osc(clk), .__rst_n(rst_n), .req_toggle(req_a), .op(op_a), .addr(addr_a),
        .wdata(wdata_a), .ack_toggle(ack_a), .busy(busy_a), .rdata(rdata_a),
        .verify_fail(vf_a), .zif_addr(zaddr_a), .zif_dout(zdout_a), .zif_din(din_a),
        .zif_dout_en(den_a), .zif_ce_n(ce_a), .zif_oe_n(oe_a), .zif_pgm_n(pgm_a),
        .vpp_en(vpp_a)
    );

    zif_prog_sequencer #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_READ(1)) dut_b (
        .__osc(clk), .__rst_n(rst_n), .req_toggle(req_b), .op(op_b), .addr(addr_b),
        .wdata(wdata_b), .ack_toggle(ack_b), .busy(busy_b), .rdata(rdata_b),
        .verify_fail(vf_b), .zif_addr(zaddr_b), .zif_dout(zdout_b), .zif_din(din_b),
        .zif_dout_en(den_b), .zif_ce_n(ce_b), .zif_oe_n(oe_b), .zif_pgm_n(pgm_b),
        .vpp_en(vpp_b)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle activity counters and scoreboard consumer, sampled mid-cycle.
    initial begin
        ack_prev = 1'b0;
        ce_lo = 0; oe_lo = 0; pgm_lo = 0; vpp_hi = 0; den_hi = 0; busy_hi = 0;
        dout_bad = 0; ovl = 0; pgm_b_lo = 0; oe_b_lo = 0;
        forever begin
            @(negedge clk);
            if (!ce_a) ce_lo++;
            if (!oe_a) oe_lo++;
            if (!pgm_a) pgm_lo++;
            if (vpp_a) vpp_hi++;
            if (den_a) den_hi++;
            if (busy_a) busy_hi++;
            if (den_a && (zdout_a !== exp_dout)) dout_bad++;
            if ((!pgm_a && !oe_a) || (den_a && !oe_a)) ovl++;
            if ((!pgm_b && !oe_b) || (den_b && !oe_b)) ovl++;
            if (!pgm_b) pgm_b_lo++;
            if (!oe_b) oe_b_lo++;
            if (rst_n && (ack_a !== ack_prev)) begin
                if (sb_q.size() == 0) begin
                    chk_val("sb_unexpected_ack", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk_val("sb_ack", {31'd0, ack_a}, {31'd0, mon_e.ack});
                    chk_val("sb_rdata", {24'd0, rdata_a}, {24'd0, mon_e.rdata});
                    chk_val("sb_vfail", {31'd0, vf_a}, {31'd0, mon_e.vf});
                    chk_val("sb_busy", {31'd0, busy_a}, 32'd0);
                end
            end
            ack_prev = ack_a;
        end
    end

    // Issue one command on instance A, push its expected result, wait for ack.
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [7:0] w,
                          input logic [7:0] din, output int lat);
        exp_t e;
        @(negedge clk);
        op_a = o; addr_a = a; wdata_a = w; din_a = din; exp_dout = w;
        if (o == 2'b00 || o == 2'b10) model_rd = din;
        e.rdata = model_rd;
        e.vf    = (o == 2'b10) ? (din != w) : 1'b0;
        e.ack   = ~req_a;
        sb_q.push_back(e);
        req_a = ~req_a;
        lat = 0;
        while (ack_a !== req_a && lat < 5000) begin
            @(posedge clk); #1;
            lat++;
        end
        if (ack_a !== req_a) chk_val("ack_timeout", 32'd0, 32'd1);
        @(negedge clk); #1;
    endtask

    int lat;
    int c0, o0, p0, v0, d0, b0, db0, ov0;

    task automatic snap();
        c0 = ce_lo; o0 = oe_lo; p0 = pgm_lo; v0 = vpp_hi; d0 = den_hi; b0 = busy_hi; db0 = dout_bad;
    endtask

    initial begin
        total = 0; bad = 0; model_rd = 8'h00; exp_dout = 8'h00;
        rst_n = 1'b0;
        req_a = 1'b0; op_a = 2'b00; addr_a = 16'h0000; wdata_a = 8'h00; din_a = 8'h00;
        req_b = 1'b0; op_b = 2'b00; addr_b = 16'h0000; wdata_b = 8'h00; din_b = 8'h00;
        repeat (3) @(negedge clk);
        chk_val("rst_ack_busy", {30'd0, ack_a, busy_a}, 32'd0);
        chk_val("rst_rdata_vf", {23'd0, rdata_a, vf_a}, 32'd0);
        chk_val("rst_addr_dout", {8'd0, zaddr_a, zdout_a}, 32'd0);
        chk_val("rst_drive", {30'd0, den_a, vpp_a}, 32'd0);
        chk_val("rst_strobes", {29'd0, ce_a, oe_a, pgm_a}, 32'd7);
        rst_n = 1'b1;
        ov0 = ovl;

        // Read
        snap();
        run_op(2'b00, 16'h1234, 8'h00, 8'hA5, lat);
        chk_val("rd_ce_len", 32'(ce_lo - c0), 32'd36);
        chk_val("rd_oe_len", 32'(oe_lo - o0), 32'd12);
        chk_val("rd_pgm_vpp", 32'((pgm_lo - p0) + (vpp_hi - v0) + (den_hi - d0)), 32'd0);
        chk_val("rd_busy_len", 32'(busy_hi - b0), 32'd37);
        chk_val("rd_zaddr", {16'd0, zaddr_a}, 32'h1234);
        chk_val("rd_latency", {31'd0, (lat >= 38 && lat <= 41)}, 32'd1);

        // Program
        snap();
        run_op(2'b01, 16'h0040, 8'h3C, 8'h00, lat);
        chk_val("pg_vpp_len", 32'(vpp_hi - v0), 32'd2448);
        chk_val("pg_den_len", 32'(den_hi - d0), 32'd2448);
        chk_val("pg_pgm_len", 32'(pgm_lo - p0), 32'd2400);
        chk_val("pg_ce_len", 32'(ce_lo - c0), 32'd2448);
        chk_val("pg_oe_len", 32'(oe_lo - o0), 32'd0);
        chk_val("pg_dout_val", 32'(dout_bad - db0), 32'd0);
        chk_val("pg_dout_keep", {24'd0, zdout_a}, 32'h3C);
        chk_val("pg_latency", {31'd0, (lat >= 2450 && lat <= 2453)}, 32'd1);

        // Verify pass, verify fail, read clears the fail flag
        run_op(2'b10, 16'h0041, 8'h55, 8'h55, lat);
        run_op(2'b10, 16'h0042, 8'h55, 8'h54, lat);
        chk_val("vf_flag_set", {31'd0, vf_a}, 32'd1);
        run_op(2'b00, 16'h0043, 8'h00, 8'h77, lat);

        // Reserved op: quick ack, no socket activity, rdata untouched
        snap();
        run_op(2'b11, 16'hBEEF, 8'hFF, 8'h11, lat);
        chk_val("rsv_activity", 32'((ce_lo - c0) + (oe_lo - o0) + (pgm_lo - p0) + (vpp_hi - v0)), 32'd0);
        chk_val("rsv_latency", {31'd0, (lat >= 2 && lat <= 5)}, 32'd1);
        chk_val("rsv_rdata", {24'd0, rdata_a}, 32'h77);
        chk_val("sb_drained", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of a program pulse
        @(negedge clk);
        op_a = 2'b01; addr_a = 16'h0100; wdata_a = 8'hC3; exp_dout = 8'hC3;
        req_a = ~req_a;
        repeat (3 + 24 + 1000) @(posedge clk);
        #1;
        chk_val("mid_pulse_pgm", {30'd0, pgm_a, vpp_a}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_val("rst_async_drive", {29'd0, vpp_a, den_a, busy_a}, 32'd0);
        chk_val("rst_async_pgm", {30'd0, pgm_a, ce_a}, 32'd3);
        req_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        snap();
        repeat (50) @(negedge clk);
        chk_val("post_rst_idle", {30'd0, ack_a, busy_a}, 32'd0);
        chk_val("post_rst_activity", 32'((ce_lo - c0) + (vpp_hi - v0)), 32'd0);

        // Unit-timing instance: back-to-back program then read
        p0 = pgm_b_lo; o0 = oe_b_lo;
        @(negedge clk);
        op_b = 2'b01; addr_b = 16'h0007; wdata_b = 8'h5A; din_b = 8'h00;
        req_b = 1'b1;
        lat = 0;
        while (ack_b !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk_val("b_ack1", {31'd0, ack_b}, 32'd1);
        chk_val("b_lat1", {31'd0, (lat >= 5 && lat <= 8)}, 32'd1);
        op_b = 2'b00; din_b = 8'h9A;
        req_b = 1'b0;
        lat = 0;
        while (ack_b !== 1'b0 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk_val("b_ack0", {31'd0, ack_b}, 32'd0);
        chk_val("b_lat2", {31'd0, (lat >= 4 && lat <= 7)}, 32'd1);
        @(negedge clk);
        chk_val("b_pgm_len", 32'(pgm_b_lo - p0), 32'd1);
        chk_val("b_oe_len", 32'(oe_b_lo - o0), 32'd1);
        chk_val("b_rdata", {24'd0, rdata_b}, 32'h9A);
        chk_val("b_busy", {31'd0, busy_b}, 32'd0);

        chk_val("strobe_overlap", 32'(ovl - ov0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
